ttt_turn_sequencer: RTL

Turn sequencer and board owner for the tic-tac-toe game.
- Debounces the select key and decodes the one-hot switch move.
- Arbitrates turns between player 1 and player 2 and validates each move.
- Writes the board, evaluates win/tie, maintains per-player scores and sequences reset of the board after each result.
- Sits between the board I/O (SW, KEY) and the VGA renderer, 7-segment score decoders and LEDR state display.

---
 rtl/ttt_pkg.sv | 60 ++++++
 rtl/ttt_win_eval.sv | 44 ++++
 rtl/ttt_turn_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn sequencer and its win evaluator.
package ttt_pkg;

  typedef enum logic [2:0] {
    ST_PLAY,
    ST_CHECK_MOVE,
    ST_WRITE,
    ST_CHECK_WIN,
    ST_P1_WIN,
    ST_P2_WIN,
    ST_TIE,
    ST_CLEAR
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_P1   = 2'd1,
    RES_P2   = 2'd2,
    RES_TIE  = 2'd3
  } result_e;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  // Scan order matters: the first completed line decides the result.
  localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [6:0] state_to_onehot(input state_e s);
    logic [6:0] oh;
    case (s)
      ST_PLAY:                oh = 7'b0000001;
      ST_CHECK_MOVE:          oh = 7'b0000010;
      ST_WRITE, ST_CHECK_WIN: oh = 7'b0000100;
      ST_P1_WIN:              oh = 7'b0001000;
      ST_P2_WIN:              oh = 7'b0010000;
      ST_TIE:                 oh = 7'b0100000;
      ST_CLEAR:               oh = 7'b1000000;
      default:                oh = 7'b0000001;
    endcase
    return oh;
  endfunction

  function automatic logic is_onehot9(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

endpackage

// File: rtl/ttt_win_eval.sv
// Combinational board judge: first completed line in scan order wins, otherwise a full board is a tie.
module ttt_win_eval
  import ttt_pkg::*;
(
  input  logic [17:0] board_i,
  output result_e     result_o
);

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] k);
    return b[{k, 1'b0} +: 2];
  endfunction

  logic       full;
  logic       found;
  logic [1:0] ca;
  logic [1:0] cb;
  logic [1:0] cc;

  always_comb begin
    full = 1'b1;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (board_i[2*k +: 2] == CELL_EMPTY) full = 1'b0;
    end

    found    = 1'b0;
    ca       = CELL_EMPTY;
    cb       = CELL_EMPTY;
    cc       = CELL_EMPTY;
    result_o = RES_NONE;
    for (int l = 0; l < NUM_LINES; l++) begin
      ca = cell_at(board_i, WIN_LINES[l][0]);
      cb = cell_at(board_i, WIN_LINES[l][1]);
      cc = cell_at(board_i, WIN_LINES[l][2]);
      if (!found && (ca != CELL_EMPTY) && (ca == cb) && (ca == cc)) begin
        found    = 1'b1;
        result_o = (ca == CELL_P1) ? RES_P1 : RES_P2;
      end
    end

    // A completed line outranks a full board.
    if (!found && full) result_o = RES_TIE;
  end

endmodule

// File: rtl/ttt_turn_sequencer.sv
// Tic-tac-toe turn sequencer: debounces the select key, validates and writes moves,
// judges the board, keeps scores and sequences the post-result hold and board clear.
module ttt_turn_sequencer
  import ttt_pkg::*;
#(
  parameter int unsigned POLL_CYCLES      = 10000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4,
  parameter int unsigned HOLD_CYCLES      = 50000000,
  parameter int unsigned SCORE_MAX        = 9
) (
  input  logic        MAX10_CLK1_50,
  input  logic        rst,
  input  logic        select_n,
  input  logic [8:0]  move,
  output logic [17:0] board_o,
  output logic        player,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [6:0]  state_onehot,
  output logic        err_invalid
);

  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int DEB_W  = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_SAMPLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]        SCORE_TOP = 4'(SCORE_MAX);

  logic [1:0]        sync_q;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic              filt_q, filt_d;
  logic              press_q, press_d;

  state_e            state_q, state_d;
  logic [8:0]        mv_q, mv_d;
  logic [17:0]       board_q, board_d;
  logic              player_q, player_d;
  logic [3:0]        score1_q, score1_d;
  logic [3:0]        score2_q, score2_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              err_q, err_d;
  logic [6:0]        onehot_q;

  result_e           result;
  logic              occupied;
  logic              move_ok;

  // Key filter: filt_q tracks the select_n level (1 = released) and only
  // follows the synchronised key after enough consecutive disagreeing samples.
  always_comb begin
    poll_d  = poll_q + 1'b1;
    deb_d   = deb_q;
    filt_d  = filt_q;
    press_d = 1'b0;
    if (poll_q == POLL_LAST) begin
      poll_d = '0;
      if (sync_q[1] == filt_q) begin
        deb_d = '0;
      end else if (deb_q == DEB_LAST) begin
        deb_d   = '0;
        filt_d  = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end
  end

  ttt_win_eval u_win_eval (
    .board_i  (board_q),
    .result_o (result)
  );

  always_comb begin
    occupied = 1'b0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (mv_q[k] && (board_q[2*k +: 2] != CELL_EMPTY)) occupied = 1'b1;
    end
  end

  assign move_ok = is_onehot9(mv_q) && !occupied;

  always_comb begin
    state_d  = state_q;
    mv_d     = mv_q;
    board_d  = board_q;
    player_d = player_q;
    score1_d = score1_q;
    score2_d = score2_q;
    hold_d   = hold_q;
    err_d    = 1'b0;

    case (state_q)
      ST_PLAY: begin
        if (press_q) begin
          mv_d    = move;
          state_d = ST_CHECK_MOVE;
        end
      end
      ST_CHECK_MOVE: begin
        if (move_ok) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_PLAY;
          err_d   = 1'b1;
        end
      end
      ST_WRITE: begin
        for (int k = 0; k < NUM_CELLS; k++) begin
          if (mv_q[k]) board_d[2*k +: 2] = player_q ? CELL_P2 : CELL_P1;
        end
        player_d = ~player_q;
        state_d  = ST_CHECK_WIN;
      end
      ST_CHECK_WIN: begin
        hold_d = '0;
        case (result)
          RES_P1: begin
            state_d = ST_P1_WIN;
            if (score1_q < SCORE_TOP) score1_d = score1_q + 4'd1;
          end
          RES_P2: begin
            state_d = ST_P2_WIN;
            if (score2_q < SCORE_TOP) score2_d = score2_q + 4'd1;
          end
          RES_TIE: state_d = ST_TIE;
          default: state_d = ST_PLAY;
        endcase
      end
      ST_P1_WIN, ST_P2_WIN, ST_TIE: begin
        if (hold_q == HOLD_LAST) state_d = ST_CLEAR;
        else                     hold_d  = hold_q + 1'b1;
      end
      ST_CLEAR: begin
        board_d  = '0;
        player_d = 1'b0;
        if ((score1_q >= SCORE_TOP) || (score2_q >= SCORE_TOP)) begin
          score1_d = '0;
          score2_d = '0;
        end
        state_d = ST_PLAY;
      end
      default: state_d = ST_PLAY;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) begin
      sync_q   <= 2'b11;
      poll_q   <= '0;
      deb_q    <= '0;
      filt_q   <= 1'b1;
      press_q  <= 1'b0;
      state_q  <= ST_PLAY;
      board_q  <= '0;
      player_q <= 1'b0;
      score1_q <= '0;
      score2_q <= '0;
      hold_q   <= '0;
      err_q    <= 1'b0;
      onehot_q <= 7'b0000001;
    end else begin
      sync_q   <= {sync_q[0], select_n};
      poll_q   <= poll_d;
      deb_q    <= deb_d;
      filt_q   <= filt_d;
      press_q  <= press_d;
      state_q  <= state_d;
      board_q  <= board_d;
      player_q <= player_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      onehot_q <= state_to_onehot(state_d);
    end
  end

  // The move latch is only meaningful after a press, so it needs no reset.
  always_ff @(posedge MAX10_CLK1_50) begin
    mv_q <= mv_d;
  end

  assign board_o      = board_q;
  assign player       = player_q;
  assign score1       = score1_q;
  assign score2       = score2_q;
  assign state_onehot = onehot_q;
  assign err_invalid  = err_q;

endmodule
